// File: rtl/sccb_seq_config_if.sv
`timescale 1ns/1ps
// Purpose: bundle of table, SCCB pin and status signals for sccb_seq_config.
// Latency: wiring only, no storage.
// Backpressure: none; iSTART is a single-cycle pulse, the table answers one cycle after oTBL_ADDR.
// Ports: iSTART/iTBL_LEN start a run; oTBL_ADDR/iTBL_DATA read the table; I2C_* are the camera pins;
//        oBUSY/oDONE/oERR/oERR_INDEX/oLUT_INDEX report progress.
interface sccb_seq_config_if #(
  parameter int IDX_W = 8,
  parameter int SUB_W = 8
);
  logic               iSTART;
  logic [IDX_W-1:0]   iTBL_LEN;
  logic [IDX_W-1:0]   oTBL_ADDR;
  logic [SUB_W+7:0]   iTBL_DATA;
  logic               I2C_SCLK;
  logic               I2C_SDA_OE;
  logic               I2C_SDA_IN;
  logic               oBUSY;
  logic               oDONE;
  logic               oERR;
  logic [IDX_W-1:0]   oERR_INDEX;
  logic [IDX_W-1:0]   oLUT_INDEX;

  // The sequencer is the bus master on the camera side.
  modport master (
    input  iSTART, iTBL_LEN, iTBL_DATA, I2C_SDA_IN,
    output oTBL_ADDR, I2C_SCLK, I2C_SDA_OE, oBUSY, oDONE, oERR, oERR_INDEX, oLUT_INDEX
  );

  // Environment view: controller, table RAM and camera pins.
  modport slave (
    output iSTART, iTBL_LEN, iTBL_DATA, I2C_SDA_IN,
    input  oTBL_ADDR, I2C_SCLK, I2C_SDA_OE, oBUSY, oDONE, oERR, oERR_INDEX, oLUT_INDEX
  );
endinterface

// File: rtl/sccb_seq_config.sv
`timescale 1ns/1ps
// Purpose: walks a register table and writes each {sub, data} entry to an SCCB/I2C slave, with retry and delay entries.
// Latency: table fetch 2 cycles; one frame = START + (bytes*9 bit slots) + STOP + GAP, 4 ticks each.
// Backpressure: none; iSTART is ignored while oBUSY, NACKs retry up to MAX_RETRY times then flag oERR.
// Ports: iCLK/iRST plain; bus (master modport) carries table, SCL/SDA pins and status.
module sccb_seq_config #(
  parameter int               CLK_FREQ   = 25_000_000,
  parameter int               I2C_FREQ   = 100_000,
  parameter logic [7:0]       SLAVE_ADDR = 8'h42,
  parameter int               SUB_W      = 8,
  parameter int               IDX_W      = 8,
  parameter int               MAX_RETRY  = 3,
  parameter int               IGNORE_ACK = 0,
  parameter logic [SUB_W-1:0] DELAY_MARK = {SUB_W{1'b1}}
) (
  input  logic              iCLK,
  input  logic              iRST,
  sccb_seq_config_if.master bus
);

  localparam int DIV_RAW = CLK_FREQ / (4 * I2C_FREQ);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int MS_RAW  = CLK_FREQ / 1000;
  localparam int MS_CYC  = (MS_RAW < 1) ? 1 : MS_RAW;
  localparam int MS_W    = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
  localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int FRM_W   = SUB_W + 16;
  localparam logic [1:0] LAST_BYTE = (SUB_W == 16) ? 2'd3 : 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_START, S_SHIFT, S_ACK,
    S_STOP, S_GAP, S_WAIT, S_NEXT, S_FIN, S_FAIL
  } state_t;

  state_t             r_state;
  logic [DIV_W-1:0]   r_div;
  logic [1:0]         r_q;
  logic [2:0]         r_bit;
  logic [1:0]         r_byte;
  logic [FRM_W-1:0]   r_frame;
  logic [SUB_W+7:0]   r_entry;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_len;
  logic [IDX_W-1:0]   r_err_idx;
  logic [RTY_W-1:0]   r_retry;
  logic [MS_W-1:0]    r_ms;
  logic [7:0]         r_dly;
  logic               r_fetch;
  logic               r_fail;
  logic               r_scl;
  logic               r_oe;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               w_tick;
  logic               w_nack;

  assign bus.oTBL_ADDR  = r_idx;
  assign bus.oLUT_INDEX = r_idx;
  assign bus.oERR_INDEX = r_err_idx;
  assign bus.I2C_SCLK   = r_scl;
  assign bus.I2C_SDA_OE = r_oe;
  assign bus.oBUSY      = r_busy;
  assign bus.oDONE      = r_done;
  assign bus.oERR       = r_err;

  // Quarter-bit tick; the divider only runs during a sequence.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)                            r_div <= '0;
    else if (!r_busy)                    r_div <= '0;
    else if (r_div == DIV_W'(DIV - 1))   r_div <= '0;
    else                                 r_div <= r_div + 1'b1;
  end

  assign w_tick = r_busy && (r_div == DIV_W'(DIV - 1));
  assign w_nack = (IGNORE_ACK == 0) && bus.I2C_SDA_IN;

  // Bus states act on each tick: r_q names the phase being entered, and
  // every bus state leaves on q3 so r_q is back at 0 for the next one.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state   <= S_IDLE;
      r_q       <= '0;
      r_bit     <= '0;
      r_byte    <= '0;
      r_frame   <= '0;
      r_entry   <= '0;
      r_idx     <= '0;
      r_len     <= '0;
      r_err_idx <= '0;
      r_retry   <= '0;
      r_ms      <= '0;
      r_dly     <= '0;
      r_fetch   <= 1'b0;
      r_fail    <= 1'b0;
      r_scl     <= 1'b1;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_scl <= 1'b1;
          r_oe  <= 1'b0;
          if (bus.iSTART) begin
            r_len   <= bus.iTBL_LEN;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_retry <= '0;
            r_fetch <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        // Address is already on oTBL_ADDR; the RAM answers one cycle later.
        S_FETCH: begin
          r_fetch <= ~r_fetch;
          if (r_fetch) begin
            r_entry <= bus.iTBL_DATA;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_q    <= '0;
          r_fail <= 1'b0;
          r_ms   <= '0;
          r_dly  <= r_entry[7:0];
          if (r_idx == r_len)                             r_state <= S_FIN;
          else if (r_entry[SUB_W+7:8] == DELAY_MARK)      r_state <= S_WAIT;
          else                                            r_state <= S_START;
        end
        S_START: if (w_tick) begin
          r_q <= r_q + 2'd1;
          case (r_q)
            2'd0: begin r_scl <= 1'b1; r_oe <= 1'b0; end
            2'd1: r_oe <= 1'b1;
            2'd3: begin
              r_scl   <= 1'b0;
              r_frame <= {SLAVE_ADDR & 8'hFE, r_entry};
              r_bit   <= '0;
              r_byte  <= '0;
              r_state <= S_SHIFT;
            end
            default: begin end
          endcase
        end
        S_SHIFT: if (w_tick) begin
          r_q <= r_q + 2'd1;
          case (r_q)
            2'd0: begin r_scl <= 1'b0; r_oe <= ~r_frame[FRM_W-1]; end
            2'd1: r_scl <= 1'b1;
            2'd3: begin
              r_scl   <= 1'b0;
              r_frame <= {r_frame[FRM_W-2:0], 1'b0};
              r_bit   <= r_bit + 3'd1;
              if (r_bit == 3'd7) r_state <= S_ACK;
            end
            default: begin end
          endcase
        end
        S_ACK: if (w_tick) begin
          r_q <= r_q + 2'd1;
          case (r_q)
            2'd0: begin r_scl <= 1'b0; r_oe <= 1'b0; end
            2'd1: r_scl <= 1'b1;
            2'd2: if (w_nack) r_fail <= 1'b1;
            default: begin
              r_scl <= 1'b0;
              // A NACK abandons the rest of the frame.
              if (r_fail || r_byte == LAST_BYTE) begin
                r_state <= S_STOP;
              end else begin
                r_byte  <= r_byte + 2'd1;
                r_state <= S_SHIFT;
              end
            end
          endcase
        end
        S_STOP: if (w_tick) begin
          r_q <= r_q + 2'd1;
          case (r_q)
            2'd0: begin r_scl <= 1'b0; r_oe <= 1'b1; end
            2'd1: r_scl <= 1'b1;
            2'd2: r_oe <= 1'b0;
            default: r_state <= S_GAP;
          endcase
        end
        S_GAP: if (w_tick) begin
          r_q <= r_q + 2'd1;
          if (r_q == 2'd3) begin
            if (!r_fail) begin
              r_state <= S_NEXT;
            end else if (r_retry == RTY_W'(MAX_RETRY)) begin
              r_state <= S_FAIL;
            end else begin
              r_retry <= r_retry + 1'b1;
              r_fail  <= 1'b0;
              r_state <= S_START;
            end
          end
        end
        S_WAIT: begin
          if (r_dly == 8'd0) begin
            r_state <= S_NEXT;
          end else if (r_ms == MS_W'(MS_CYC - 1)) begin
            r_ms  <= '0;
            r_dly <= r_dly - 8'd1;
          end else begin
            r_ms <= r_ms + 1'b1;
          end
        end
        S_NEXT: begin
          r_idx   <= r_idx + 1'b1;
          r_retry <= '0;
          r_fetch <= 1'b0;
          r_state <= S_FETCH;
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_FAIL: begin
          r_err     <= 1'b1;
          r_err_idx <= r_idx;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_seq_config.sv
`timescale 1ns/1ps
// Purpose: directed bench for sccb_seq_config with an SCCB slave model that decodes frames.
// Latency: n/a.
// Backpressure: slave NACKs a chosen sub-address a bounded number of times.
module tb_sccb_seq_config;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sccb_seq_config_if #(.IDX_W(8), .SUB_W(8))  if0();
  sccb_seq_config_if #(.IDX_W(8), .SUB_W(16)) if1();

  sccb_seq_config #(.CLK_FREQ(400_000), .I2C_FREQ(100_000), .SUB_W(8))
    u0 (.iCLK(clk), .iRST(rst), .bus(if0));
  sccb_seq_config #(.CLK_FREQ(400_000), .I2C_FREQ(100_000), .SUB_W(16))
    u1 (.iCLK(clk), .iRST(rst), .bus(if1));

  logic [15:0] tbl0 [0:15];
  logic [23:0] tbl1 [0:3];

  always @(posedge clk) begin
    if0.iTBL_DATA <= tbl0[if0.oTBL_ADDR[3:0]];
    if1.iTBL_DATA <= tbl1[if1.oTBL_ADDR[1:0]];
  end

  int n_chk = 0;
  int n_pass = 0;

  // Slave / monitor for bus 0. Events: -1 START, -2 STOP, else a byte.
  int         ev0[$];
  int         bit0 = 0, byte0 = 0, rise0 = 0, nack_used = 0;
  logic [7:0] sh0 = 8'h00;
  logic       ack0 = 1'b0, pscl0 = 1'b1, psda0 = 1'b1;
  logic [7:0] nack_sub = 8'h00;
  int         nack_limit = 0;
  wire        sda0 = ~if0.I2C_SDA_OE & ~ack0;
  assign if0.I2C_SDA_IN = sda0;

  always @(if0.I2C_SCLK or sda0) begin
    if (pscl0 === 1'b1 && if0.I2C_SCLK === 1'b1 && psda0 === 1'b1 && sda0 === 1'b0) begin
      ev0.push_back(-1); bit0 = 0; byte0 = 0;
    end else if (pscl0 === 1'b1 && if0.I2C_SCLK === 1'b1 && psda0 === 1'b0 && sda0 === 1'b1) begin
      ev0.push_back(-2);
    end else if (pscl0 !== 1'b1 && if0.I2C_SCLK === 1'b1) begin
      rise0++;
      if (bit0 < 8) sh0 = {sh0[6:0], sda0};
      bit0++;
      if (bit0 == 8) ev0.push_back(int'(sh0));
    end else if (pscl0 === 1'b1 && if0.I2C_SCLK === 1'b0) begin
      if (bit0 == 8) begin
        if (byte0 == 1 && sh0 == nack_sub && nack_used < nack_limit) begin
          ack0 = 1'b0; nack_used++;
        end else begin
          ack0 = 1'b1;
        end
      end else if (bit0 >= 9) begin
        ack0 = 1'b0; bit0 = 0; byte0++;
      end
    end
    pscl0 = if0.I2C_SCLK;
    psda0 = sda0;
  end

  // Slave / monitor for bus 1, always ACKs.
  int         ev1[$];
  int         bit1 = 0;
  logic [7:0] sh1 = 8'h00;
  logic       ack1 = 1'b0, pscl1 = 1'b1, psda1 = 1'b1;
  wire        sda1 = ~if1.I2C_SDA_OE & ~ack1;
  assign if1.I2C_SDA_IN = sda1;

  always @(if1.I2C_SCLK or sda1) begin
    if (pscl1 === 1'b1 && if1.I2C_SCLK === 1'b1 && psda1 === 1'b1 && sda1 === 1'b0) begin
      ev1.push_back(-1); bit1 = 0;
    end else if (pscl1 === 1'b1 && if1.I2C_SCLK === 1'b1 && psda1 === 1'b0 && sda1 === 1'b1) begin
      ev1.push_back(-2);
    end else if (pscl1 !== 1'b1 && if1.I2C_SCLK === 1'b1) begin
      if (bit1 < 8) sh1 = {sh1[6:0], sda1};
      bit1++;
      if (bit1 == 8) ev1.push_back(int'(sh1));
    end else if (pscl1 === 1'b1 && if1.I2C_SCLK === 1'b0) begin
      if (bit1 == 8) ack1 = 1'b1;
      else if (bit1 >= 9) begin ack1 = 1'b0; bit1 = 0; end
    end
    pscl1 = if1.I2C_SCLK;
    psda1 = sda1;
  end

  function automatic string evs(input int q[$], input int base);
    string s;
    s = "";
    for (int i = base; i < q.size(); i++) begin
      if (q[i] == -1)      s = {s, "S "};
      else if (q[i] == -2) s = {s, "P "};
      else                 s = {s, $sformatf("%02x ", q[i] & 255)};
    end
    return s;
  endfunction

  task automatic pulse0(input logic [7:0] len);
    @(negedge clk); if0.iTBL_LEN = len; if0.iSTART = 1'b1;
    @(negedge clk); if0.iSTART = 1'b0;
  endtask

  task automatic pulse1(input logic [7:0] len);
    @(negedge clk); if1.iTBL_LEN = len; if1.iSTART = 1'b1;
    @(negedge clk); if1.iSTART = 1'b0;
  endtask

  task automatic wait_idle0(output bit ok);
    int n = 0;
    while (if0.oBUSY === 1'b1 && n < 20000) begin @(negedge clk); n++; end
    ok = (if0.oBUSY === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if0.iSTART = 1'b0; if0.iTBL_LEN = '0;
    if1.iSTART = 1'b0; if1.iTBL_LEN = '0;
    for (int i = 0; i < 16; i++) tbl0[i] = 16'h0000;
    for (int i = 0; i < 4; i++)  tbl1[i] = 24'h000000;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({if0.I2C_SCLK, if0.I2C_SDA_OE, if0.oBUSY, if0.oDONE, if0.oERR} !== 5'b10000)
      $display("FAIL reset_pins got=%b exp=10000", {if0.I2C_SCLK, if0.I2C_SDA_OE, if0.oBUSY, if0.oDONE, if0.oERR});
    else n_pass++;
    n_chk++;
    if ({if0.oTBL_ADDR, if0.oLUT_INDEX, if0.oERR_INDEX} !== 24'h0)
      $display("FAIL reset_idx got=%h exp=000000", {if0.oTBL_ADDR, if0.oLUT_INDEX, if0.oERR_INDEX});
    else n_pass++;
    n_chk++;
    if ({if1.I2C_SCLK, if1.I2C_SDA_OE, if1.oBUSY} !== 3'b100)
      $display("FAIL reset_u1 got=%b exp=100", {if1.I2C_SCLK, if1.I2C_SDA_OE, if1.oBUSY});
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({if0.I2C_SCLK, if0.oBUSY} !== 2'b10)
      $display("FAIL idle_after_reset got=%b exp=10", {if0.I2C_SCLK, if0.oBUSY});
    else n_pass++;
  endtask

  task automatic test_single_write();
    int base, r; bit ok; string s;
    tbl0[0] = 16'h1280;
    base = ev0.size(); r = rise0;
    pulse0(8'd1);
    wait_idle0(ok);
    n_chk++; if (!ok) $display("FAIL single_timeout got=busy exp=idle"); else n_pass++;
    s = evs(ev0, base);
    n_chk++; if (s != "S 42 12 80 P ") $display("FAIL single_bytes got=%s exp=S 42 12 80 P", s); else n_pass++;
    n_chk++;
    if ({if0.oDONE, if0.oBUSY, if0.oERR} !== 3'b100)
      $display("FAIL single_status got=%b exp=100", {if0.oDONE, if0.oBUSY, if0.oERR});
    else n_pass++;
    n_chk++; if (if0.oLUT_INDEX !== 8'd1) $display("FAIL single_lut got=%0d exp=1", if0.oLUT_INDEX); else n_pass++;
    // 27 bit slots plus the SCL rise inside STOP.
    n_chk++; if (rise0 - r != 28) $display("FAIL single_scl_rises got=%0d exp=28", rise0 - r); else n_pass++;
  endtask

  task automatic test_sub16();
    int base, n; string s;
    tbl1[0] = 24'h300842;
    base = ev1.size();
    pulse1(8'd1);
    n = 0;
    while (if1.oBUSY === 1'b1 && n < 20000) begin @(negedge clk); n++; end
    s = evs(ev1, base);
    n_chk++; if (s != "S 42 30 08 42 P ") $display("FAIL sub16_bytes got=%s exp=S 42 30 08 42 P", s); else n_pass++;
    n_chk++;
    if ({if1.oDONE, if1.oBUSY} !== 2'b10) $display("FAIL sub16_status got=%b exp=10", {if1.oDONE, if1.oBUSY});
    else n_pass++;
  endtask

  task automatic test_retry();
    int base; bit ok; string s;
    tbl0[0] = 16'h10a0; tbl0[1] = 16'h11a1; tbl0[2] = 16'h12a2;
    nack_sub = 8'h11; nack_limit = nack_used + 2;
    base = ev0.size();
    pulse0(8'd3);
    wait_idle0(ok);
    n_chk++; if (!ok) $display("FAIL retry_timeout got=busy exp=idle"); else n_pass++;
    s = evs(ev0, base);
    n_chk++;
    if (s != "S 42 10 a0 P S 42 11 P S 42 11 P S 42 11 a1 P S 42 12 a2 P ")
      $display("FAIL retry_bytes got=%s exp=S 42 10 a0 P S 42 11 P S 42 11 P S 42 11 a1 P S 42 12 a2 P", s);
    else n_pass++;
    n_chk++;
    if ({if0.oDONE, if0.oERR} !== 2'b10) $display("FAIL retry_status got=%b exp=10", {if0.oDONE, if0.oERR});
    else n_pass++;
    n_chk++; if (if0.oLUT_INDEX !== 8'd3) $display("FAIL retry_lut got=%0d exp=3", if0.oLUT_INDEX); else n_pass++;
  endtask

  task automatic test_fail();
    int base; bit ok; string s;
    tbl0[0] = 16'h10a0; tbl0[1] = 16'h11a1; tbl0[2] = 16'h13a3; tbl0[3] = 16'h14a4;
    nack_sub = 8'h13; nack_limit = nack_used + 100;
    base = ev0.size();
    pulse0(8'd4);
    wait_idle0(ok);
    nack_limit = nack_used;
    n_chk++; if (!ok) $display("FAIL fail_timeout got=busy exp=idle"); else n_pass++;
    s = evs(ev0, base);
    n_chk++;
    if (s != "S 42 10 a0 P S 42 11 a1 P S 42 13 P S 42 13 P S 42 13 P S 42 13 P ")
      $display("FAIL fail_bytes got=%s exp=S 42 10 a0 P S 42 11 a1 P S 42 13 P S 42 13 P S 42 13 P S 42 13 P", s);
    else n_pass++;
    n_chk++;
    if ({if0.oERR, if0.oDONE} !== 2'b10) $display("FAIL fail_status got=%b exp=10", {if0.oERR, if0.oDONE});
    else n_pass++;
    n_chk++; if (if0.oERR_INDEX !== 8'd2) $display("FAIL fail_err_index got=%0d exp=2", if0.oERR_INDEX); else n_pass++;
    n_chk++; if (if0.oLUT_INDEX !== 8'd2) $display("FAIL fail_lut got=%0d exp=2", if0.oLUT_INDEX); else n_pass++;
    pulse0(8'd0);
    n_chk++; if (if0.oERR !== 1'b0) $display("FAIL restart_clears_err got=%b exp=0", if0.oERR); else n_pass++;
    wait_idle0(ok);
    n_chk++; if (if0.oDONE !== 1'b1) $display("FAIL restart_done got=%b exp=1", if0.oDONE); else n_pass++;
  endtask

  task automatic test_delay();
    int base, n; bit ok; string s;
    tbl0[0] = 16'hff02; tbl0[1] = 16'h1234;
    base = ev0.size();
    pulse0(8'd2);
    n = 0;
    while (ev0.size() == base && n < 2000) begin @(negedge clk); n++; end
    // 2 ms at 400 cycles/ms, plus fetch/decode overhead before START.
    n_chk++; if (n < 800 || n > 830) $display("FAIL delay_cycles got=%0d exp=800..830", n); else n_pass++;
    wait_idle0(ok);
    s = evs(ev0, base);
    n_chk++; if (s != "S 42 12 34 P ") $display("FAIL delay_bytes got=%s exp=S 42 12 34 P", s); else n_pass++;
    n_chk++; if (if0.oDONE !== 1'b1) $display("FAIL delay_done got=%b exp=1", if0.oDONE); else n_pass++;
  endtask

  task automatic test_rst_mid();
    int base, r, n; bit ok; string s;
    tbl0[0] = 16'h1280;
    r = rise0;
    pulse0(8'd1);
    n = 0;
    while (rise0 - r < 3 && n < 500) begin @(negedge clk); n++; end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({if0.I2C_SCLK, if0.I2C_SDA_OE, if0.oBUSY} !== 3'b100)
      $display("FAIL async_reset got=%b exp=100", {if0.I2C_SCLK, if0.I2C_SDA_OE, if0.oBUSY});
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    base = ev0.size();
    pulse0(8'd1);
    wait_idle0(ok);
    s = evs(ev0, base);
    n_chk++; if (s != "S 42 12 80 P ") $display("FAIL rst_restart_bytes got=%s exp=S 42 12 80 P", s); else n_pass++;
    n_chk++; if (if0.oLUT_INDEX !== 8'd1) $display("FAIL rst_restart_lut got=%0d exp=1", if0.oLUT_INDEX); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int base; bit ok; string s;
    tbl0[0] = 16'h2001; tbl0[1] = 16'h2102;
    base = ev0.size();
    pulse0(8'd2);
    repeat (30) @(negedge clk);
    pulse0(8'd0);
    wait_idle0(ok);
    s = evs(ev0, base);
    n_chk++;
    if (s != "S 42 20 01 P S 42 21 02 P ") $display("FAIL busy_ignore_bytes got=%s exp=S 42 20 01 P S 42 21 02 P", s);
    else n_pass++;
    n_chk++;
    if ({if0.oDONE, if0.oLUT_INDEX} !== {1'b1, 8'd2})
      $display("FAIL busy_ignore_status got=%b/%0d exp=1/2", if0.oDONE, if0.oLUT_INDEX);
    else n_pass++;
  endtask

  task automatic test_len0();
    int r, n;
    r = rise0;
    pulse0(8'd0);
    n = 0;
    while (if0.oDONE !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n_chk++; if (n > 4) $display("FAIL len0_latency got=%0d exp<=4", n); else n_pass++;
    n_chk++; if (rise0 != r) $display("FAIL len0_scl_rises got=%0d exp=0", rise0 - r); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_sub16();
    test_retry();
    test_fail();
    test_delay();
    test_rst_mid();
    test_back_to_back();
    test_len0();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
